pipepcir: RTL and testbench

Sequential front-end register block for the five-stage pipelined CPU. It holds the program counter that addresses the fetch stage. It captures the fetch stage's outputs (`npc`, `pc4`, `ins`) into the IF/ID pipeline register, and applies hazard-unit stalls and branch/jump flushes. It sits between the fetch stage, whose outputs it registers, and the decode stage, whose inputs it drives. It also keeps stall and flush event counters for performance debug.

---
 rtl/pipepcir_if.sv | 26 ++
 rtl/pipepcir.sv | 117 +++++++++++
 tb/tb_pipepcir.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipepcir_if.sv
// Fetch/decode boundary bus for the PC/IF-ID register block.
// The slave side is the register block; the master side is whoever drives the
// fetch-stage results and hazard controls (the CPU datapath or a testbench).
interface pipepcir_if;
  logic [31:0] npc;
  logic [31:0] pc4;
  logic [31:0] ins;
  logic        wpcir;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] dpc4;
  logic [31:0] dinst;
  logic        dvalid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  npc, pc4, ins, wpcir, flush,
    output pc, dpc4, dinst, dvalid, stall_cnt, flush_cnt
  );

  modport master (
    output npc, pc4, ins, wpcir, flush,
    input  pc, dpc4, dinst, dvalid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipepcir.sv
// Program counter and IF/ID pipeline register for the five-stage CPU.
// Applies load-use stalls (wpcir=0) and wrong-path flushes. A flush seen
// while stalled is remembered in kill_pending and turned into exactly one
// bubble on the next advancing edge. Saturating stall/flush event counters
// are kept for performance debug. All outputs come straight from flops.
module pipepcir #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic     clock,
  input  logic     reset,
  pipepcir_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] dinst_q, dinst_d;
  logic        dvalid_q, dvalid_d;
  logic        kill_pending_q, kill_pending_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  assign bus.pc        = pc_q;
  assign bus.dpc4      = dpc4_q;
  assign bus.dinst     = dinst_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // State register: reset wins over everything, including a pending kill.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      dpc4_q         <= 32'h0000_0000;
      dinst_q        <= NOP_INST;
      dvalid_q       <= 1'b0;
      kill_pending_q <= 1'b0;
      stall_cnt_q    <= 16'h0000;
      flush_cnt_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      dpc4_q         <= dpc4_d;
      dinst_q        <= dinst_d;
      dvalid_q       <= dvalid_d;
      kill_pending_q <= kill_pending_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  // Next-state logic: BOOT always advances once, then RUN/STALL follow wpcir.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    dpc4_d         = dpc4_q;
    dinst_d        = dinst_q;
    dvalid_d       = dvalid_q;
    kill_pending_d = kill_pending_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;

    case (state_q)
      BOOT: begin
        // First fetch after reset is always on the correct path.
        pc_d     = bus.npc;
        dpc4_d   = bus.pc4;
        dinst_d  = bus.ins;
        dvalid_d = 1'b1;
        state_d  = RUN;
      end

      RUN, STALL: begin
        if (bus.wpcir) begin
          state_d = RUN;
          pc_d    = bus.npc;
          if (bus.flush || kill_pending_q) begin
            // One bubble per advance, even if a live and a remembered flush coincide.
            dpc4_d         = 32'h0000_0000;
            dinst_d        = NOP_INST;
            dvalid_d       = 1'b0;
            kill_pending_d = 1'b0;
            if (flush_cnt_q != 16'hFFFF) begin
              flush_cnt_d = flush_cnt_q + 16'd1;
            end
          end else begin
            dpc4_d   = bus.pc4;
            dinst_d  = bus.ins;
            dvalid_d = 1'b1;
          end
        end else begin
          // Hold PC and IF/ID; a flush here only arms the bubble for later.
          state_d = STALL;
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
          if (bus.flush) begin
            kill_pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pipepcir.sv
// Directed bench for pipepcir: a vector table covering straight-line fetch,
// stalls, flushes and flush-during-stall, plus hand sequences for reset/BOOT
// and stall-counter saturation.
module tb_pipepcir;

  logic clock;
  logic reset;

  pipepcir_if bus ();

  pipepcir #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wpcir;
    logic        flush;
    logic [31:0] npc;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic [31:0] exp_pc;
    logic [31:0] exp_dpc4;
    logic [31:0] exp_dinst;
    logic        exp_dvalid;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic f, input logic [31:0] n,
                       input logic [31:0] p4, input logic [31:0] i);
    bus.wpcir = w;
    bus.flush = f;
    bus.npc   = n;
    bus.pc4   = p4;
    bus.ins   = i;
  endtask

  initial begin
    //         wpcir flush npc           pc4           ins            pc            dpc4          dinst         dv  stall     flush
    // straight line from pc=4
    vecs[0]  = '{1'b1, 1'b0, 32'h008, 32'h008, 32'hA000_0004, 32'h008, 32'h008, 32'hA000_0004, 1'b1, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h00C, 32'h00C, 32'hA000_0008, 32'h00C, 32'h00C, 32'hA000_0008, 1'b1, 16'd0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h010, 32'h010, 32'hA000_000C, 32'h010, 32'h010, 32'hA000_000C, 1'b1, 16'd0, 16'd0};
    // 3-cycle stall at pc=0x10
    vecs[3]  = '{1'b0, 1'b0, 32'h014, 32'h014, 32'hA000_0010, 32'h010, 32'h010, 32'hA000_000C, 1'b1, 16'd1, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h014, 32'h014, 32'hA000_0010, 32'h010, 32'h010, 32'hA000_000C, 1'b1, 16'd2, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'h014, 32'h014, 32'hA000_0010, 32'h010, 32'h010, 32'hA000_000C, 1'b1, 16'd3, 16'd0};
    // resume, no bubble after a plain stall
    vecs[6]  = '{1'b1, 1'b0, 32'h014, 32'h014, 32'hA000_0010, 32'h014, 32'h014, 32'hA000_0010, 1'b1, 16'd3, 16'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'h018, 32'h018, 32'hA000_0014, 32'h018, 32'h018, 32'hA000_0014, 1'b1, 16'd3, 16'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'h01C, 32'h01C, 32'hA000_0018, 32'h01C, 32'h01C, 32'hA000_0018, 1'b1, 16'd3, 16'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'h020, 32'h020, 32'hA000_001C, 32'h020, 32'h020, 32'hA000_001C, 1'b1, 16'd3, 16'd0};
    // flush while advancing to 0x100
    vecs[10] = '{1'b1, 1'b1, 32'h100, 32'h024, 32'hA000_0020, 32'h100, 32'h000, 32'h0000_0000, 1'b0, 16'd3, 16'd1};
    vecs[11] = '{1'b1, 1'b0, 32'h104, 32'h104, 32'hA000_0100, 32'h104, 32'h104, 32'hA000_0100, 1'b1, 16'd3, 16'd1};
    // flush during stall: held, then one bubble, then valid again
    vecs[12] = '{1'b0, 1'b1, 32'h200, 32'h108, 32'hA000_0104, 32'h104, 32'h104, 32'hA000_0100, 1'b1, 16'd4, 16'd1};
    vecs[13] = '{1'b1, 1'b0, 32'h108, 32'h108, 32'hA000_0104, 32'h108, 32'h000, 32'h0000_0000, 1'b0, 16'd4, 16'd2};
    vecs[14] = '{1'b1, 1'b0, 32'h10C, 32'h10C, 32'hA000_0108, 32'h10C, 32'h10C, 32'hA000_0108, 1'b1, 16'd4, 16'd2};
    // pending kill plus live flush on the same advance counts once
    vecs[15] = '{1'b0, 1'b1, 32'h110, 32'h110, 32'hA000_010C, 32'h10C, 32'h10C, 32'hA000_0108, 1'b1, 16'd5, 16'd2};
    vecs[16] = '{1'b1, 1'b1, 32'h300, 32'h110, 32'hA000_010C, 32'h300, 32'h000, 32'h0000_0000, 1'b0, 16'd5, 16'd3};
    vecs[17] = '{1'b1, 1'b0, 32'h304, 32'h304, 32'hA000_0300, 32'h304, 32'h304, 32'hA000_0300, 1'b1, 16'd5, 16'd3};

    // Reset for 2 cycles with BOOT-edge inputs already present.
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h4, 32'h4, 32'h2001_0005);
    step();
    step();
    $display("reset: pc=%h dinst=%h dvalid=%b", bus.pc, bus.dinst, bus.dvalid);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_dvalid", {31'd0, bus.dvalid}, 32'd0);
    chk("reset_dinst", bus.dinst, 32'h0);
    chk("reset_dpc4", bus.dpc4, 32'h0);
    chk("reset_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

    // BOOT edge
    reset = 1'b0;
    step();
    $display("boot: pc=%h dpc4=%h dinst=%h dvalid=%b", bus.pc, bus.dpc4, bus.dinst, bus.dvalid);
    chk("boot_pc", bus.pc, 32'h4);
    chk("boot_dinst", bus.dinst, 32'h2001_0005);
    chk("boot_dvalid", {31'd0, bus.dvalid}, 32'd1);
    chk("boot_dpc4", bus.dpc4, 32'h4);
    chk("boot_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("boot_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].wpcir, vecs[v].flush, vecs[v].npc, vecs[v].pc4, vecs[v].ins);
      step();
      $display("vec %0d: wpcir=%b flush=%b pc=%h dpc4=%h dinst=%h dvalid=%b stall=%0d flush_cnt=%0d",
               v, vecs[v].wpcir, vecs[v].flush, bus.pc, bus.dpc4, bus.dinst, bus.dvalid,
               bus.stall_cnt, bus.flush_cnt);
      chk($sformatf("vec%0d_pc", v), bus.pc, vecs[v].exp_pc);
      chk($sformatf("vec%0d_dpc4", v), bus.dpc4, vecs[v].exp_dpc4);
      chk($sformatf("vec%0d_dinst", v), bus.dinst, vecs[v].exp_dinst);
      chk($sformatf("vec%0d_dvalid", v), {31'd0, bus.dvalid}, {31'd0, vecs[v].exp_dvalid});
      chk($sformatf("vec%0d_stall_cnt", v), {16'd0, bus.stall_cnt}, {16'd0, vecs[v].exp_stall});
      chk($sformatf("vec%0d_flush_cnt", v), {16'd0, bus.flush_cnt}, {16'd0, vecs[v].exp_flush});
    end

    // Saturation: stall_cnt is 5 here; 65529 more stalls reach 0xFFFE.
    // The first stall cycle also carries a flush to arm kill_pending.
    drive(1'b0, 1'b1, 32'h308, 32'h308, 32'hA000_0304);
    step();
    bus.flush = 1'b0;
    repeat (65528) step();
    $display("sat1: stall_cnt=%h pc=%h", bus.stall_cnt, bus.pc);
    chk("sat_fffe", {16'd0, bus.stall_cnt}, 32'h0000_FFFE);
    chk("sat_pc_held", bus.pc, 32'h304);
    step();
    $display("sat2: stall_cnt=%h", bus.stall_cnt);
    chk("sat_ffff", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
    repeat (70000 - 65530) step();
    $display("sat3: stall_cnt=%h dinst=%h dvalid=%b", bus.stall_cnt, bus.dinst, bus.dvalid);
    chk("sat_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
    chk("sat_dinst_held", bus.dinst, 32'hA000_0300);
    chk("sat_dvalid_held", {31'd0, bus.dvalid}, 32'd1);

    // Reset pulse with kill_pending armed.
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset2: pc=%h stall_cnt=%h flush_cnt=%h", bus.pc, bus.stall_cnt, bus.flush_cnt);
    chk("reset2_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("reset2_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);
    chk("reset2_pc", bus.pc, 32'h0);

    // BOOT ignores wpcir=0 and flush=1.
    drive(1'b0, 1'b1, 32'h4, 32'h4, 32'h2001_0005);
    step();
    $display("boot2: pc=%h dinst=%h dvalid=%b stall=%0d", bus.pc, bus.dinst, bus.dvalid, bus.stall_cnt);
    chk("boot2_pc", bus.pc, 32'h4);
    chk("boot2_dvalid", {31'd0, bus.dvalid}, 32'd1);
    chk("boot2_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

    // No bubble afterwards: kill_pending was cleared by reset.
    drive(1'b1, 1'b0, 32'h8, 32'h8, 32'hB000_0004);
    step();
    $display("post: pc=%h dinst=%h dvalid=%b flush_cnt=%0d", bus.pc, bus.dinst, bus.dvalid, bus.flush_cnt);
    chk("post_pc", bus.pc, 32'h8);
    chk("post_dvalid", {31'd0, bus.dvalid}, 32'd1);
    chk("post_dinst", bus.dinst, 32'hB000_0004);
    chk("post_flush_cnt", {16'd0, bus.flush_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
